// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants, types and hex glyph table for the 7-segment scan controller
package seg7_pkg;

    localparam int NUM_DIGITS  = 4;
    localparam int DEAD_CYCLES = 1;

    // Segment vector: bit 0 = a, bit 1 = b, ... bit 6 = g; 1 = lit
    typedef logic [6:0] seg_t;

    // Display word: one nibble, dp bit and blank bit per digit
    typedef struct packed {
        logic [4*NUM_DIGITS-1:0] data;
        logic [NUM_DIGITS-1:0]   dp;
        logic [NUM_DIGITS-1:0]   blank;
    } disp_t;

    // Dark until the first word is loaded
    localparam disp_t DISP_RESET = '{data: '0, dp: '0, blank: '1};

    // Standard hex glyphs, b and d lowercase
    localparam seg_t GLYPHS [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// rtl/seg7_scan_ctrl_if.sv - display-word load handshake between user logic and the scan controller
interface seg7_scan_ctrl_if;
    logic        load;
    logic [15:0] data_in;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic        ready;

    modport master (output load, output data_in, output dp_in, output blank_in, input ready);
    modport slave  (input load, input data_in, input dp_in, input blank_in, output ready);
endinterface

// File: rtl/seg7_hex_decode.sv
// rtl/seg7_hex_decode.sv - combinational nibble to segment pattern decoder
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output seg_t       seg
);

    assign seg = GLYPHS[nibble];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - 4-digit 7-segment scan controller; option SEG7_LEADING_ZERO_BLANK_EN
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  rst,
    seg7_scan_ctrl_if.slave       bus,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [NUM_DIGITS-1:0] digit_sel,
    output logic                  frame_done
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    disp_t                 disp_q, disp_d;
    disp_t                 pend_q, pend_d;
    logic                  valid_q, valid_d;
    logic                  wrap_q, wrap_d;
    seg_t                  seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] digit_sel_q, digit_sel_d;
    logic                  frame_done_q, frame_done_d;

    logic                  digit_tc;
    logic                  boundary;
    logic [3:0]            nibble;
    seg_t                  glyph;
    logic [NUM_DIGITS-1:0] lz_mask;
    logic                  blank_sel;

    assign digit_tc = (cnt_q == CNT_LAST);
    assign boundary = digit_tc && (idx_q == IDX_LAST);
    assign nibble   = disp_q.data[{idx_q, 2'b00} +: 4];

    seg7_hex_decode u_hex_decode (
        .nibble (nibble),
        .seg    (glyph)
    );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic zero_run;

    // Auto-blank upper digits that are part of a run of leading zeros with no dp lit
    always_comb begin
        lz_mask  = '0;
        zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_run   = zero_run & (disp_q.data[4*i +: 4] == 4'h0);
            lz_mask[i] = zero_run & ~disp_q.dp[i];
        end
    end
`else
    assign lz_mask = '0;
`endif

    assign blank_sel = disp_q.blank[idx_q] | lz_mask[idx_q];

    // Next-state: scan counters, tear-free handshake, and output pipeline stage
    always_comb begin
        cnt_d  = digit_tc ? '0 : cnt_q + 1'b1;
        idx_d  = digit_tc ? idx_q + 1'b1 : idx_q;
        disp_d = disp_q;
        pend_d = pend_q;
        valid_d = valid_q;

        // Pending word moves to the display only at the frame wrap
        if (boundary && valid_q) begin
            disp_d  = pend_q;
            valid_d = 1'b0;
        end
        // Accept only when nothing is pending; a load on the wrap cycle waits a frame
        if (bus.load && !valid_q) begin
            pend_d  = '{data: bus.data_in, dp: bus.dp_in, blank: bus.blank_in};
            valid_d = 1'b1;
        end

        seg_d        = blank_sel ? '0 : glyph;
        dp_d         = ~blank_sel & disp_q.dp[idx_q];
        digit_sel_d  = (int'(cnt_q) < DEAD_CYCLES) ? '0 : (NUM_DIGITS'(1) << idx_q);
        wrap_d       = boundary;
        frame_done_d = wrap_q;
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            disp_q       <= DISP_RESET;
            pend_q       <= '0;
            valid_q      <= 1'b0;
            wrap_q       <= 1'b0;
            seg_q        <= '0;
            dp_q         <= 1'b0;
            digit_sel_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            disp_q       <= disp_d;
            pend_q       <= pend_d;
            valid_q      <= valid_d;
            wrap_q       <= wrap_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            digit_sel_q  <= digit_sel_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.ready  = ~valid_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign digit_sel  = digit_sel_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb/tb_seg7_scan_ctrl.sv - directed self-checking bench for seg7_scan_ctrl
module tb_seg7_scan_ctrl;

    logic       clk;
    logic       rst;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] digit_sel;
    logic       frame_done;

    int checks   = 0;
    int failures = 0;

    seg7_scan_ctrl_if bus ();

    seg7_scan_ctrl #(.REFRESH_DIV(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .seg        (seg),
        .dp         (dp),
        .digit_sel  (digit_sel),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive_load(input logic [15:0] data, input logic [3:0] dps, input logic [3:0] blanks);
        bus.load     = 1'b1;
        bus.data_in  = data;
        bus.dp_in    = dps;
        bus.blank_in = blanks;
        @(negedge clk);
        bus.load     = 1'b0;
    endtask

    task automatic wait_frame();
        for (int i = 0; i < 40; i++) begin
            if (frame_done === 1'b1) break;
            @(negedge clk);
        end
        check_eq("frame_wait", frame_done, 1'b1);
    endtask

    // Starting on the frame_done cycle, check all 16 output cycles of one frame
    task automatic check_frame(input logic [27:0] segs, input logic [3:0] dps);
        for (int k = 0; k < 16; k++) begin
            int d;
            d = k / 4;
            check_eq("frame_done", frame_done, (k == 0));
            check_eq("digit_sel", digit_sel, (k % 4 == 0) ? 4'b0000 : (4'b0001 << d));
            check_eq("seg", seg, segs[7*d +: 7]);
            check_eq("dp", dp, dps[d]);
            @(negedge clk);
        end
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_ready", bus.ready, 1'b1);
        check_eq("rst_seg", seg, 7'h00);
        check_eq("rst_dp", dp, 1'b0);
        check_eq("rst_digit_sel", digit_sel, 4'b0000);
        check_eq("rst_frame_done", frame_done, 1'b0);
    endtask

    initial begin
        rst          = 1'b1;
        bus.load     = 1'b0;
        bus.data_in  = '0;
        bus.dp_in    = '0;
        bus.blank_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;

        // Idle after reset: scanning but dark
        wait_frame();
        check_eq("idle_ready", bus.ready, 1'b1);
        check_frame({7'h00, 7'h00, 7'h00, 7'h00}, 4'b0000);

        // Load 1234 mid-frame, second load while busy is ignored
        drive_load(16'h1234, 4'b0100, 4'b0000);
        check_eq("busy_ready", bus.ready, 1'b0);
        @(negedge clk);
        drive_load(16'hFFFF, 4'b1111, 4'b0000);
        check_eq("still_busy", bus.ready, 1'b0);
        wait_frame();
        check_eq("applied_ready", bus.ready, 1'b1);
        check_frame({7'h06, 7'h5B, 7'h4F, 7'h66}, 4'b0100);

        // Load on the frame-boundary cycle: deferred by one frame
        wait_frame();
        repeat (14) @(negedge clk);
        drive_load(16'hABCD, 4'b0001, 4'b0000);
        check_eq("bnd_busy", bus.ready, 1'b0);
        wait_frame();
        check_eq("bnd_pending", bus.ready, 1'b0);
        check_frame({7'h06, 7'h5B, 7'h4F, 7'h66}, 4'b0100);
        wait_frame();
        check_eq("bnd_applied", bus.ready, 1'b1);
        check_frame({7'h77, 7'h7C, 7'h39, 7'h5E}, 4'b0001);

        // Leading zeros
        drive_load(16'h0050, 4'b0000, 4'b0000);
        wait_frame();
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        check_frame({7'h00, 7'h00, 7'h6D, 7'h3F}, 4'b0000);
`else
        check_frame({7'h3F, 7'h3F, 7'h6D, 7'h3F}, 4'b0000);
`endif

        // Explicit blanking kills seg and dp while digit_sel still scans
        drive_load(16'h8888, 4'b1111, 4'b0110);
        wait_frame();
        check_frame({7'h7F, 7'h00, 7'h00, 7'h7F}, 4'b1001);

        // Reset mid-frame with a pending word
        wait_frame();
        repeat (3) @(negedge clk);
        drive_load(16'h5555, 4'b1111, 4'b0000);
        check_eq("pre_rst_busy", bus.ready, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;
        wait_frame();
        check_eq("post_rst_ready", bus.ready, 1'b1);
        check_frame({7'h00, 7'h00, 7'h00, 7'h00}, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
